// File: rtl/par_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : par_io_pkg
//  Description : Shared definitions for the parallel I/O port: host register
//                addresses, STATUS bit positions and a STATUS byte builder.
//  Revision    : 1.0  initial release
// ============================================================================
package par_io_pkg;

    // Host register map.
    typedef enum logic [1:0] {
        ADDR_OUT    = 2'd0,
        ADDR_DIR    = 2'd1,
        ADDR_RXDATA = 2'd2,
        ADDR_STATUS = 2'd3
    } reg_addr_e;

    // STATUS register bit positions.
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 5;

    // Assemble the 8-bit STATUS image; the caller sizes it to the bus width.
    function automatic logic [7:0] status_byte(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [4:0] cnt
    );
        logic [7:0] s;
        s                               = '0;
        s[STAT_EMPTY]                   = empty;
        s[STAT_FULL]                    = full;
        s[STAT_OVF]                     = ovf;
        s[STAT_CNT_LSB +: STAT_CNT_W]   = cnt;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/par_io_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : par_io_fifo
//  Description : Synchronous receive FIFO with occupancy count. Push while
//                full is accepted only when a pop happens in the same cycle;
//                pop while empty is ignored. Head entry is shown
//                combinationally on head.
//  Ports       : clk, rst (async, active-low), push, pop, wdata -> head,
//                full, empty, count (0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module par_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    // When full, the slot under the write pointer is the head being popped,
    // so a simultaneous push can reuse it.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/par_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : par_io_port
//  Description : Host-controlled bidirectional parallel port. OUT/DIR
//                registers drive the pads; an asynchronous capture strobe
//                samples the input pads into a receive FIFO.
//  Ports       : clk, rst (async, active-low)
//                addr/wr_en/rd_en/wdata -> rdata   host register interface
//                pad (inout)                        bidirectional pins
//                stb_in                             async capture strobe
//                irq                                FIFO non-empty or overflow
//  Revision    : 1.0  initial release
// ============================================================================
module par_io_port
    import par_io_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    inout  wire  [WIDTH-1:0] pad,
    input  logic             stb_in,
    output logic             irq
);

    localparam int c_cnt_w = $clog2(RX_DEPTH) + 1;

    logic [WIDTH-1:0]       r_out;
    logic [WIDTH-1:0]       r_dir;
    logic                   r_ovf;
    logic [WIDTH-1:0]       r_rdata;
    logic                   r_irq;

    logic [WIDTH-1:0]       r_pad_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_stb_sync;
    logic [SYNC_STAGES-1:0] r_sync_valid;
    logic                   r_stb_prev;

    logic                   w_stb_last;
    logic                   w_valid_last;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovf_evt;
    logic                   w_wr_status;
    logic [WIDTH-1:0]       w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [c_cnt_w-1:0]     w_count;
    logic [7:0]             w_status8;
    logic [WIDTH-1:0]       w_status;
    logic [WIDTH-1:0]       w_rd_mux;

    // ------------------------------------------------------------------
    // Pad drivers: per-bit tri-state controlled by DIR.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign pad[i] = r_dir[i] ? r_out[i] : 1'bz;
    end

    // ------------------------------------------------------------------
    // Synchronisers. r_sync_valid marks when the last stage holds a real
    // post-reset sample; until then r_stb_prev is held high so that a
    // strobe already high at reset release is not seen as a rising edge.
    // ------------------------------------------------------------------
    assign w_stb_last   = r_stb_sync[SYNC_STAGES-1];
    assign w_valid_last = r_sync_valid[SYNC_STAGES-1];
    assign w_push       = w_valid_last & w_stb_last & ~r_stb_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_pad_sync[s] <= '0;
            end
            r_stb_sync   <= '0;
            r_sync_valid <= '0;
            r_stb_prev   <= 1'b1;
        end else begin
            r_pad_sync[0] <= pad;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_pad_sync[s] <= r_pad_sync[s-1];
            end
            r_stb_sync   <= {r_stb_sync[SYNC_STAGES-2:0], stb_in};
            r_sync_valid <= {r_sync_valid[SYNC_STAGES-2:0], 1'b1};
            r_stb_prev   <= w_valid_last ? w_stb_last : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO. Output-direction bits are masked off before storing.
    // ------------------------------------------------------------------
    assign w_pop = rd_en & (addr == ADDR_RXDATA) & ~w_empty;

    par_io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (r_pad_sync[SYNC_STAGES-1] & ~r_dir),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // ------------------------------------------------------------------
    // Register file and host read path.
    // ------------------------------------------------------------------
    assign w_ovf_evt   = w_push & w_full & ~w_pop;
    assign w_wr_status = wr_en & (addr == ADDR_STATUS);
    assign w_status8   = status_byte(w_empty, w_full, r_ovf, 5'(w_count));
    assign w_status    = WIDTH'(w_status8);

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            ADDR_OUT:    w_rd_mux = r_out;
            ADDR_DIR:    w_rd_mux = r_dir;
            ADDR_RXDATA: w_rd_mux = w_empty ? '0 : w_head;
            ADDR_STATUS: w_rd_mux = w_status;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (wr_en && (addr == ADDR_OUT)) begin
                r_out <= wdata;
            end
            if (wr_en && (addr == ADDR_DIR)) begin
                r_dir <= wdata;
            end
            // A new overflow outranks a clear in the same cycle.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status) begin
                r_ovf <= 1'b0;
            end
            if (rd_en) begin
                r_rdata <= w_rd_mux;
            end
            r_irq <= ~w_empty | r_ovf;
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule
`default_nettype wire
